lcd_800_480_timing_gen: RTL and testbench

//  Consumer end of the LCD pixel clock: runs on the 800x480 panel pixel clock and

---
 rtl/lcd_timing_pkg.sv | 52 +++++
 rtl/lcd_sync_delay.sv | 43 ++++
 rtl/lcd_800_480_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_lcd_800_480_timing_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, totals and phase encoding for the LCD timing generator.
// Default geometry targets an 800x480 panel.
package lcd_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FRONT  = 210;
    localparam int unsigned DEF_H_SYNC   = 1;
    localparam int unsigned DEF_H_BACK   = 45;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 22;
    localparam int unsigned DEF_V_SYNC   = 1;
    localparam int unsigned DEF_V_BACK   = 22;
    localparam bit          DEF_SYNC_POL = 1'b0;
    localparam int unsigned DEF_RGB_LAT  = 1;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    function automatic int unsigned h_total(
        input int unsigned act,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return act + front + sync + back;
    endfunction

    function automatic int unsigned v_total(
        input int unsigned act,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return act + front + sync + back;
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        unique case (ph)
            PH_ACTIVE: nxt = PH_FRONT;
            PH_FRONT:  nxt = PH_SYNC;
            PH_SYNC:   nxt = PH_BACK;
            PH_BACK:   nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_sync_delay.sv
// N-stage shift register for the {de, hs, vs} bundle; resets to the idle levels.
// With N=0 the bundle passes straight through.
module lcd_sync_delay #(
    parameter int unsigned N       = 1,
    parameter logic [2:0]  RST_VAL = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] d_in,
    output logic [2:0] d_out
);

    generate
        if (N == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign d_out = d_in;
        end else begin : g_shift
            logic [2:0] stage_q [N];
            logic [2:0] stage_d [N];

            always_comb begin
                stage_d[0] = d_in;
                for (int i = 1; i < int'(N); i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(N); i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign d_out = stage_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/lcd_800_480_timing_gen.sv
// Panel timing generator: raster counters, phase FSMs, pixel requests and
// sync/data outputs aligned to the fixed RGB return latency.
module lcd_800_480_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter bit          SYNC_POL = DEF_SYNC_POL,
    parameter int unsigned RGB_LAT  = DEF_RGB_LAT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        pix_req,
    output logic        frame_start,
    input  logic [15:0] rgb_in,
    output logic        lcd_de,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int HC_W = $clog2(H_TOTAL);
    localparam int VC_W = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_ACT_END = HC_W'(H_ACTIVE - 1);
    localparam logic [HC_W-1:0] H_FP_END  = HC_W'(H_ACTIVE + H_FRONT - 1);
    localparam logic [HC_W-1:0] H_SY_END  = HC_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [HC_W-1:0] H_TOT_END = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_END = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0] V_FP_END  = VC_W'(V_ACTIVE + V_FRONT - 1);
    localparam logic [VC_W-1:0] V_SY_END  = VC_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [VC_W-1:0] V_TOT_END = VC_W'(V_TOTAL - 1);

    localparam logic [2:0] SYNC_IDLE = {1'b0, ~SYNC_POL, ~SYNC_POL};

    generate
        if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
            H_ACTIVE < 1 || H_ACTIVE > 1024 ||
            V_ACTIVE < 1 || V_ACTIVE > 512 ||
            RGB_LAT > 4) begin : g_param_err
            $error("lcd_800_480_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;
    phase_e          h_ph_q, h_ph_d;
    phase_e          v_ph_q, v_ph_d;
    logic [HC_W-1:0] h_end;
    logic [VC_W-1:0] v_end;
    logic            h_wrap;
    logic            v_wrap;

    // Phase ends are looked up per state so the FSM never range-compares.
    always_comb begin
        unique case (h_ph_q)
            PH_ACTIVE: h_end = H_ACT_END;
            PH_FRONT:  h_end = H_FP_END;
            PH_SYNC:   h_end = H_SY_END;
            PH_BACK:   h_end = H_TOT_END;
        endcase
        unique case (v_ph_q)
            PH_ACTIVE: v_end = V_ACT_END;
            PH_FRONT:  v_end = V_FP_END;
            PH_SYNC:   v_end = V_SY_END;
            PH_BACK:   v_end = V_TOT_END;
        endcase
    end

    always_comb begin
        h_wrap = (hc_q == H_TOT_END);
        v_wrap = (vc_q == V_TOT_END);
        hc_d   = h_wrap ? '0 : hc_q + HC_W'(1);
        vc_d   = vc_q;
        h_ph_d = h_ph_q;
        v_ph_d = v_ph_q;
        if (hc_q == h_end) begin
            h_ph_d = next_phase(h_ph_q);
        end
        if (h_wrap) begin
            vc_d = v_wrap ? '0 : vc_q + VC_W'(1);
            if (vc_q == v_end) begin
                v_ph_d = next_phase(v_ph_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q   <= '0;
            vc_q   <= '0;
            h_ph_q <= PH_ACTIVE;
            v_ph_q <= PH_ACTIVE;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            h_ph_q <= h_ph_d;
            v_ph_q <= v_ph_d;
        end
    end

    logic [2:0] sync_raw;
    logic [2:0] sync_dly;

    always_comb begin
        pix_req     = (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
        frame_start = (hc_q == '0) && (vc_q == '0);
        x           = pix_req ? 10'(hc_q) : '0;
        y           = pix_req ? 9'(vc_q) : '0;
        sync_raw[2] = pix_req;
        sync_raw[1] = (h_ph_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        sync_raw[0] = (v_ph_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    lcd_sync_delay #(
        .N       (RGB_LAT),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst   (rst),
        .d_in  (sync_raw),
        .d_out (sync_dly)
    );

    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [15:0] rgb_q, rgb_d;

    // Colour is blanked here so stray data never reaches the panel outside DE.
    always_comb begin
        de_d  = sync_dly[2];
        hs_d  = sync_dly[1];
        vs_d  = sync_dly[0];
        rgb_d = sync_dly[2] ? rgb_in : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q  <= 1'b0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            rgb_q <= '0;
        end else begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
        end
    end

    assign lcd_de = de_q;
    assign lcd_hs = hs_q;
    assign lcd_vs = vs_q;
    assign lcd_r  = rgb_q[15:11];
    assign lcd_g  = rgb_q[10:5];
    assign lcd_b  = rgb_q[4:0];

endmodule

// File: tb/tb_lcd_800_480_timing_gen.sv
// Bench for lcd_800_480_timing_gen: four geometries/latencies against a raster
// model computed from cycle index arithmetic.
module tb_lcd_800_480_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] rgb   [4];
    logic [9:0]  x_o   [4];
    logic [8:0]  y_o   [4];
    logic        pix_o [4];
    logic        fs_o  [4];
    logic        de_o  [4];
    logic        hs_o  [4];
    logic        vs_o  [4];
    logic [4:0]  r_o   [4];
    logic [5:0]  g_o   [4];
    logic [4:0]  b_o   [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        int lat;
        bit pol;
    } cfg_t;

    function automatic cfg_t cfg_of(input int d);
        cfg_t c;
        case (d)
            0:       c = '{8, 2, 1, 2, 4, 1, 1, 1, 1, 1'b0};
            1:       c = '{40, 5, 2, 3, 30, 3, 2, 2, 3, 1'b1};
            2:       c = '{8, 2, 1, 2, 4, 1, 1, 1, 0, 1'b0};
            default: c = '{800, 210, 1, 45, 480, 22, 1, 22, 1, 1'b0};
        endcase
        return c;
    endfunction

    lcd_800_480_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(1), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0), .RGB_LAT(1)
    ) dut_s (
        .clk(clk), .rst(rst), .x(x_o[0]), .y(y_o[0]),
        .pix_req(pix_o[0]), .frame_start(fs_o[0]), .rgb_in(rgb[0]),
        .lcd_de(de_o[0]), .lcd_hs(hs_o[0]), .lcd_vs(vs_o[0]),
        .lcd_r(r_o[0]), .lcd_g(g_o[0]), .lcd_b(b_o[0])
    );

    lcd_800_480_timing_gen #(
        .H_ACTIVE(40), .H_FRONT(5), .H_SYNC(2), .H_BACK(3),
        .V_ACTIVE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b1), .RGB_LAT(3)
    ) dut_m (
        .clk(clk), .rst(rst), .x(x_o[1]), .y(y_o[1]),
        .pix_req(pix_o[1]), .frame_start(fs_o[1]), .rgb_in(rgb[1]),
        .lcd_de(de_o[1]), .lcd_hs(hs_o[1]), .lcd_vs(vs_o[1]),
        .lcd_r(r_o[1]), .lcd_g(g_o[1]), .lcd_b(b_o[1])
    );

    lcd_800_480_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(1), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0), .RGB_LAT(0)
    ) dut_z (
        .clk(clk), .rst(rst), .x(x_o[2]), .y(y_o[2]),
        .pix_req(pix_o[2]), .frame_start(fs_o[2]), .rgb_in(rgb[2]),
        .lcd_de(de_o[2]), .lcd_hs(hs_o[2]), .lcd_vs(vs_o[2]),
        .lcd_r(r_o[2]), .lcd_g(g_o[2]), .lcd_b(b_o[2])
    );

    lcd_800_480_timing_gen dut_d (
        .clk(clk), .rst(rst), .x(x_o[3]), .y(y_o[3]),
        .pix_req(pix_o[3]), .frame_start(fs_o[3]), .rgb_in(rgb[3]),
        .lcd_de(de_o[3]), .lcd_hs(hs_o[3]), .lcd_vs(vs_o[3]),
        .lcd_r(r_o[3]), .lcd_g(g_o[3]), .lcd_b(b_o[3])
    );

    function automatic logic [39:0] obs(input int d);
        return {pix_o[d], fs_o[d], x_o[d], y_o[d], de_o[d], hs_o[d], vs_o[d],
                r_o[d], g_o[d], b_o[d]};
    endfunction

    // Expected pins at cycle k after reset release; prev is rgb_in driven in cycle k-1.
    function automatic logic [39:0] model(input int d, input int k, input logic [15:0] prev);
        cfg_t c = cfg_of(d);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        int pos = k % (ht * vt);
        int hc = pos % ht;
        int vc = pos / ht;
        int j = k - c.lat - 1;
        int jp, jh, jv;
        logic pix = (hc < c.ha) && (vc < c.va);
        logic de = 1'b0;
        logic hs = !c.pol;
        logic vs = !c.pol;
        logic [15:0] px;
        if (j >= 0) begin
            jp = j % (ht * vt);
            jh = jp % ht;
            jv = jp / ht;
            de = (jh < c.ha) && (jv < c.va);
            if (jh >= c.ha + c.hf && jh < c.ha + c.hf + c.hs) hs = c.pol;
            if (jv >= c.va + c.vf && jv < c.va + c.vf + c.vs) vs = c.pol;
        end
        px = de ? prev : 16'h0000;
        return {pix, pos == 0, pix ? 10'(hc) : 10'd0, pix ? 9'(vc) : 9'd0,
                de, hs, vs, px};
    endfunction

    // mode 0: random, 1: {x,y,x} of the position issued lat clocks ago, 2: all ones
    function automatic logic [15:0] stim(input int d, input int mode, input int k);
        cfg_t c = cfg_of(d);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        int q = k - c.lat;
        int hc, vc;
        if (mode == 2) return 16'hFFFF;
        if (mode == 0) return 16'($urandom);
        if (q < 0) return 16'h0000;
        hc = (q % (ht * vt)) % ht;
        vc = (q % (ht * vt)) / ht;
        return {hc[4:0], vc[5:0], hc[4:0]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) rgb[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] e;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) rgb[i] = 16'hFFFF;
        repeat (4) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            cfg_t c = cfg_of(d);
            e = {1'b1, 1'b1, 10'd0, 9'd0, 1'b0, !c.pol, !c.pol, 16'h0000};
            checks++;
            if (obs(d) !== e) begin
                errors++;
                $display("FAIL reset d%0d got=%h exp=%h", d, obs(d), e);
            end
        end
    endtask

    task automatic test_small_pattern();
        logic [15:0] prev = 16'h0;
        logic [39:0] e;
        int hs_low = 0;
        int q, hc, vc;
        logic [15:0] pat;
        do_reset();
        for (int k = 0; k < 2 * 91 + 5; k++) begin
            e = model(0, k, prev);
            checks++;
            if (obs(0) !== e) begin
                errors++;
                $display("FAIL pattern k=%0d got=%h exp=%h", k, obs(0), e);
            end
            if (de_o[0]) begin
                q = (k - 2) % 91;
                hc = q % 13;
                vc = q / 13;
                pat = {hc[4:0], vc[5:0], hc[4:0]};
                checks++;
                if ({r_o[0], g_o[0], b_o[0]} !== pat) begin
                    errors++;
                    $display("FAIL pattern_pix k=%0d got=%h exp=%h", k,
                             {r_o[0], g_o[0], b_o[0]}, pat);
                end
            end
            if (k >= 2 && k < 2 + 91 && !hs_o[0]) hs_low++;
            prev = stim(0, 1, k);
            rgb[0] = prev;
            @(posedge clk);
            #1;
        end
        checks++;
        if (hs_low !== 7) begin
            errors++;
            $display("FAIL small_hs_low got=%0d exp=7", hs_low);
        end
    endtask

    task automatic test_ffff_blank(input int d);
        logic [15:0] prev = 16'h0;
        logic [39:0] e;
        do_reset();
        for (int k = 0; k < 120; k++) begin
            e = model(d, k, prev);
            checks++;
            if (obs(d) !== e) begin
                errors++;
                $display("FAIL ffff d%0d k=%0d got=%h exp=%h", d, k, obs(d), e);
            end
            if (!de_o[d]) begin
                checks++;
                if ({r_o[d], g_o[d], b_o[d]} !== 16'h0000) begin
                    errors++;
                    $display("FAIL blank d%0d k=%0d got=%h exp=0000", d, k,
                             {r_o[d], g_o[d], b_o[d]});
                end
            end
            prev = stim(d, 2, k);
            rgb[d] = prev;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_frame_counts();
        cfg_t c = cfg_of(1);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        int n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0;
        logic prev_hs = !c.pol;
        logic [15:0] prev = 16'h0;
        logic [39:0] e;
        do_reset();
        for (int k = 0; k < ht * vt + c.lat + 1; k++) begin
            e = model(1, k, prev);
            checks++;
            if (obs(1) !== e) begin
                errors++;
                $display("FAIL frame k=%0d got=%h exp=%h", k, obs(1), e);
            end
            if (k >= c.lat + 1) begin
                if (de_o[1]) n_de++;
                if (vs_o[1] == c.pol) n_vs++;
                if (hs_o[1] == c.pol && prev_hs != c.pol) n_hs++;
            end
            if (k < ht * vt && fs_o[1]) n_fs++;
            prev_hs = hs_o[1];
            prev = stim(1, 0, k);
            rgb[1] = prev;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_de !== c.ha * c.va) begin
            errors++;
            $display("FAIL de_count got=%0d exp=%0d", n_de, c.ha * c.va);
        end
        checks++;
        if (n_hs !== vt) begin
            errors++;
            $display("FAIL hs_pulses got=%0d exp=%0d", n_hs, vt);
        end
        checks++;
        if (n_vs !== c.vs * ht) begin
            errors++;
            $display("FAIL vs_clocks got=%0d exp=%0d", n_vs, c.vs * ht);
        end
        checks++;
        if (n_fs !== 1) begin
            errors++;
            $display("FAIL frame_start_count got=%0d exp=1", n_fs);
        end
    endtask

    task automatic test_latency(input int d);
        cfg_t c = cfg_of(d);
        int t_pix = -1;
        int t_de = -1;
        logic pp = 1'b1;
        logic pd = 1'b0;
        do_reset();
        for (int k = 0; k < 600 && t_de < 0; k++) begin
            if (t_pix < 0 && pix_o[d] && !pp) t_pix = k;
            else if (t_pix >= 0 && de_o[d] && !pd) t_de = k;
            pp = pix_o[d];
            pd = de_o[d];
            @(posedge clk);
            #1;
        end
        checks++;
        if (t_de < 0 || t_de - t_pix !== c.lat + 1) begin
            errors++;
            $display("FAIL latency d%0d got=%0d exp=%0d", d, t_de - t_pix, c.lat + 1);
        end
    endtask

    task automatic test_reset_mid();
        cfg_t c = cfg_of(1);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int stop = 15 * ht + 20;
        logic [15:0] prev = 16'h0;
        logic [39:0] e;
        do_reset();
        for (int k = 0; k <= stop; k++) begin
            e = model(1, k, prev);
            checks++;
            if (obs(1) !== e) begin
                errors++;
                $display("FAIL pre_rst k=%0d got=%h exp=%h", k, obs(1), e);
            end
            if (k == stop) break;
            prev = stim(1, 0, k);
            rgb[1] = prev;
            @(posedge clk);
            #1;
        end
        rgb[1] = 16'hFFFF;
        rst = 1'b1;
        #1;
        e = {1'b1, 1'b1, 10'd0, 9'd0, 1'b0, !c.pol, !c.pol, 16'h0000};
        checks++;
        if (obs(1) !== e) begin
            errors++;
            $display("FAIL mid_rst got=%h exp=%h", obs(1), e);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        prev = 16'h0;
        for (int k = 0; k < 200; k++) begin
            e = model(1, k, prev);
            checks++;
            if (obs(1) !== e) begin
                errors++;
                $display("FAIL post_rst k=%0d got=%h exp=%h", k, obs(1), e);
            end
            prev = stim(1, 0, k);
            rgb[1] = prev;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [15:0] prev = 16'h0;
        logic [39:0] e;
        do_reset();
        for (int k = 0; k < n; k++) begin
            e = model(d, k, prev);
            checks++;
            if (obs(d) !== e) begin
                errors++;
                $display("FAIL random d%0d k=%0d got=%h exp=%h", d, k, obs(d), e);
            end
            prev = stim(d, 0, k);
            rgb[d] = prev;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_small_pattern();
        test_ffff_blank(0);
        test_random(2, 200);
        test_frame_counts();
        test_latency(2);
        test_latency(1);
        test_reset_mid();
        test_random(3, 2 * 1056 + 20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
